// File: rtl/response_misr_checker_pkg.sv
// Shared definitions for the response MISR checker: FSM encoding, default
// polynomial/seed and the signature next-state function.
package response_misr_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // Widest signature the shared step function supports.
    localparam int MAX_W = 64;

    // One MISR step for a signature of sig_w bits (sig_w < MAX_W): shift left,
    // fold the outgoing MSB back through poly, then xor in the data word.
    function automatic logic [MAX_W-1:0] misr_step(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] poly,
        input logic [MAX_W-1:0] din,
        input int               sig_w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb_vec;
        logic [MAX_W-1:0] shifted;
        mask    = (64'd1 << sig_w) - 64'd1;
        msb_vec = sig >> (sig_w - 1);
        shifted = (sig << 1) & mask;
        return (shifted ^ (msb_vec[0] ? poly : '0) ^ din) & mask;
    endfunction

endpackage

// File: rtl/response_misr_checker_misr_reg.sv
// Signature register: async reset to SEED, synchronous re-seed on load,
// one MISR step per shift.
module misr_reg
    import response_misr_checker_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               W     = 3,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [MAX_W-1:0] w_full;
    logic [SIG_W-1:0] w_next;
    logic             w_unused_hi;

    assign w_full      = misr_step(MAX_W'(r_sig), MAX_W'(POLY), MAX_W'(din), SIG_W);
    assign w_next      = w_full[SIG_W-1:0];
    // Bits above SIG_W are masked to zero by the step function.
    assign w_unused_hi = ^w_full[MAX_W-1:SIG_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sig <= SEED;
        end else if (load) begin
            r_sig <= SEED;
        end else if (shift) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/response_misr_checker.sv
// Response checker top: run-control FSM, accepted-word counter and final
// signature compare around the misr_reg signature register.
module response_misr_checker
    import response_misr_checker_pkg::*;
#(
    parameter int               W       = 3,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
    parameter int               N_WORDS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [W-1:0]     resp,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      word_count,
    output logic [1:0]       state_dbg
);

    localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [15:0]      r_count;
    logic             r_pass;
    logic             r_busy;
    logic             r_done;
    logic [SIG_W-1:0] w_sig;
    logic             w_start;
    logic             w_accept;
    logic             w_last;

    // start is only honoured between runs; resp_valid only while running.
    assign w_start  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept = resp_valid && (r_state == ST_RUN);
    assign w_last   = w_accept && (r_count == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_RUN;
            ST_RUN:   if (w_last)  w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_DONE;
            ST_DONE:  if (w_start) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next-state decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN) || (w_state_next == ST_CHECK);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_start) begin
            r_count <= 16'd0;
        end else if (w_accept) begin
            r_count <= r_count + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pass <= 1'b0;
        end else if (w_start) begin
            r_pass <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_pass <= (w_sig == expected_sig);
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .W     (W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clock (clock),
        .reset (reset),
        .load  (w_start),
        .shift (w_accept),
        .din   (resp),
        .sig   (w_sig)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign signature  = w_sig;
    assign word_count = r_count;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_response_misr_checker.sv
// Bench for response_misr_checker: two instances (4-word and 1-word runs),
// randomized words, a polynomial-arithmetic reference model and a done-edge scoreboard.
module tb_response_misr_checker;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        a_start = 1'b0, a_valid = 1'b0;
  logic [2:0]  a_resp = 3'd0;
  logic [15:0] a_exp = 16'd0;
  logic        a_busy, a_done, a_pass;
  logic [15:0] a_sig, a_cnt;
  logic [1:0]  a_state;

  logic        b_start = 1'b0, b_valid = 1'b0;
  logic [2:0]  b_resp = 3'd0;
  logic [15:0] b_exp = 16'd0;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_sig, b_cnt;
  logic [1:0]  b_state;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard entries: {pass, word_count, signature}
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  logic [32:0] ea, eb;
  logic        a_done_d = 1'b0, b_done_d = 1'b0;

  logic [15:0] m_sig;
  int          m_cnt;
  logic [2:0]  words[4];

  always #5 clock = ~clock;

  response_misr_checker #(.W(3), .SIG_W(16), .POLY(POLY), .SEED(SEED), .N_WORDS(4)) u_dut_a (
    .clock(clock), .reset(reset), .start(a_start), .resp_valid(a_valid), .resp(a_resp),
    .expected_sig(a_exp), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_sig), .word_count(a_cnt), .state_dbg(a_state)
  );

  response_misr_checker #(.W(3), .SIG_W(16), .POLY(POLY), .SEED(SEED), .N_WORDS(1)) u_dut_b (
    .clock(clock), .reset(reset), .start(b_start), .resp_valid(b_valid), .resp(b_resp),
    .expected_sig(b_exp), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_sig), .word_count(b_cnt), .state_dbg(b_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Reference: multiply signature by x modulo POLY, then add the word.
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [2:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(POLY);
    return 16'(v ^ int'(d));
  endfunction

  // Monitor: on each rising done, pop the expected completion and compare.
  always @(negedge clock) begin
    if (!reset && a_done && !a_done_d) begin
      if (exp_a_q.size() == 0) check("a_unexpected_done", 32'(a_done), 32'd0);
      else begin
        ea = exp_a_q.pop_front();
        check("a_done_sig", 32'(a_sig), 32'(ea[15:0]));
        check("a_done_cnt", 32'(a_cnt), 32'(ea[31:16]));
        check("a_done_pass", 32'(a_pass), 32'(ea[32]));
      end
    end
    if (!reset && b_done && !b_done_d) begin
      if (exp_b_q.size() == 0) check("b_unexpected_done", 32'(b_done), 32'd0);
      else begin
        eb = exp_b_q.pop_front();
        check("b_done_sig", 32'(b_sig), 32'(eb[15:0]));
        check("b_done_cnt", 32'(b_cnt), 32'(eb[31:16]));
        check("b_done_pass", 32'(b_pass), 32'(eb[32]));
      end
    end
    a_done_d = a_done;
    b_done_d = b_done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_start_run();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    m_sig = SEED;
    m_cnt = 0;
    check("a_start_busy", 32'(a_busy), 32'd1);
    check("a_start_done", 32'(a_done), 32'd0);
    check("a_start_sig", 32'(a_sig), 32'(SEED));
    check("a_start_cnt", 32'(a_cnt), 32'd0);
    check("a_start_pass", 32'(a_pass), 32'd0);
  endtask

  // gap idle cycles carrying junk on resp, then one valid word
  task automatic a_word(input logic [2:0] w, input int gap);
    for (int g = 0; g < gap; g++) begin
      a_resp = 3'($urandom_range(0, 7));
      tick();
    end
    a_valid = 1'b1;
    a_resp = w;
    tick();
    a_valid = 1'b0;
    m_sig = ref_step(m_sig, w);
    m_cnt++;
    check("a_word_sig", 32'(a_sig), 32'(m_sig));
    check("a_word_cnt", 32'(a_cnt), 32'(m_cnt));
    if (m_cnt == 4) begin
      exp_a_q.push_back({(m_sig == a_exp), 16'(m_cnt), m_sig});
      check("a_check_busy", 32'(a_busy), 32'd1);
      check("a_check_done", 32'(a_done), 32'd0);
      tick();
      check("a_fin_done", 32'(a_done), 32'd1);
      check("a_fin_busy", 32'(a_busy), 32'd0);
    end
  endtask

  task automatic a_noise(input int n);
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_resp = 3'($urandom_range(0, 7));
      tick();
    end
    a_valid = 1'b0;
    check("a_noise_sig", 32'(a_sig), 32'(m_sig));
    check("a_noise_cnt", 32'(a_cnt), 32'(m_cnt));
  endtask

  task automatic a_run_words(input bit match, input bit mid_start);
    logic [15:0] s;
    s = SEED;
    for (int i = 0; i < 4; i++) s = ref_step(s, words[i]);
    a_exp = match ? s : (s ^ 16'($urandom_range(1, 65535)));
    a_start_run();
    for (int i = 0; i < 4; i++) begin
      if (mid_start && i == 2) begin
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_mid_start_cnt", 32'(a_cnt), 32'(m_cnt));
        check("a_mid_start_busy", 32'(a_busy), 32'd1);
      end
      a_word(words[i], int'($urandom_range(0, 3)));
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) words[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic b_run(input logic [2:0] w, input bit match);
    logic [15:0] s;
    s = ref_step(SEED, w);
    b_exp = match ? s : (s ^ 16'($urandom_range(1, 65535)));
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_start_busy", 32'(b_busy), 32'd1);
    check("b_start_sig", 32'(b_sig), 32'(SEED));
    b_valid = 1'b1;
    b_resp = w;
    tick();
    b_valid = 1'b0;
    exp_b_q.push_back({match, 16'd1, s});
    check("b_word_sig", 32'(b_sig), 32'(s));
    check("b_check_done", 32'(b_done), 32'd0);
    tick();
    check("b_fin_done", 32'(b_done), 32'd1);
    check("b_fin_pass", 32'(b_pass), 32'(match));
    // valid pulses in DONE must leave the result untouched
    b_valid = 1'b1;
    b_resp = 3'($urandom_range(0, 7));
    tick();
    tick();
    b_valid = 1'b0;
    check("b_done_hold_sig", 32'(b_sig), 32'(s));
    check("b_done_hold_cnt", 32'(b_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // asynchronous reset asserted between clock edges
    #7;
    reset = 1'b1;
    #1;
    check("rst_a_state", 32'(a_state), 32'd0);
    check("rst_a_sig", 32'(a_sig), 32'(SEED));
    check("rst_a_cnt", 32'(a_cnt), 32'd0);
    check("rst_a_flags", 32'({a_busy, a_done, a_pass}), 32'd0);
    check("rst_b_sig", 32'(b_sig), 32'(SEED));
    check("rst_b_flags", 32'({b_busy, b_done, b_pass}), 32'd0);
    tick();
    reset = 1'b0;
    m_sig = SEED;
    m_cnt = 0;
    a_noise(3);

    b_run(3'b101, 1'b1);
    b_run(3'($urandom_range(0, 7)), 1'b0);

    rand_words();
    a_run_words(1'b1, 1'b0);
    a_noise(3);
    check("a_done_pass_held", 32'(a_pass), 32'd1);
    words[0] = 3'b000; words[1] = 3'b000;
    words[2] = 3'($urandom_range(0, 7)); words[3] = 3'b111;
    a_run_words(1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rand_words();
      a_run_words(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) a_noise(int'($urandom_range(1, 3)));
    end

    // abort after two of four words
    rand_words();
    a_exp = 16'h0000;
    a_start_run();
    a_word(words[0], 1);
    a_word(words[1], 0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_state", 32'(a_state), 32'd0);
    check("abort_flags", 32'({a_busy, a_done, a_pass}), 32'd0);
    check("abort_sig", 32'(a_sig), 32'(SEED));
    check("abort_cnt", 32'(a_cnt), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 32'(a_done), 32'd0);
    a_run_words(1'b1, 1'b0);

    repeat (4) tick();
    check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
